// File: rtl/bcd_countdown_timer.sv
// BCD minutes:seconds countdown timer with keypad digit entry, +30 s quick-add,
// prescaled one-second tick, pause via enable and a one-cycle completion pulse.
module bcd_countdown_timer #(
   parameter int MIN_DIGITS = 1,
   parameter int TICK_DIV   = 1
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [3:0]              data,
   input  logic                    load,
   input  logic                    add30,
   input  logic                    en,
   output logic [3:0]              sec_ones,
   output logic [3:0]              sec_tens,
   output logic [4*MIN_DIGITS-1:0] mins,
   output logic                    zero,
   output logic                    done
);

   localparam int MW = 4 * MIN_DIGITS;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [3:0]    ones_q, ones_d;
   logic [3:0]    tens_q, tens_d;
   logic [MW-1:0] mins_q, mins_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          done_q, done_d;

   logic [3:0]    ones_dec, tens_dec;
   logic          ones_borrow, min_borrow;
   logic [MW-1:0] mins_inc, mins_dec, tens_ext;
   logic          all_nines, dec_is_zero;

   assign zero     = (ones_q == 4'd0) && (tens_q == 4'd0) && (mins_q == '0);
   assign sec_ones = ones_q;
   assign sec_tens = tens_q;
   assign mins     = mins_q;
   assign done     = done_q;

   always_comb begin
      tens_ext      = '0;
      tens_ext[3:0] = tens_q;
   end

   // Seconds borrow chain; tens may hold 6..9 after keypad entry and simply counts down.
   always_comb begin
      ones_borrow = (ones_q == 4'd0);
      ones_dec    = ones_borrow ? 4'd9 : ones_q - 4'd1;
      min_borrow  = ones_borrow && (tens_q == 4'd0);
      if (!ones_borrow)
         tens_dec = tens_q;
      else if (tens_q == 4'd0)
         tens_dec = 4'd5;
      else
         tens_dec = tens_q - 4'd1;
   end

   always_comb begin : minute_arith
      logic       carry;
      logic       borrow;
      logic [3:0] dig;
      mins_inc  = '0;
      mins_dec  = '0;
      all_nines = 1'b1;
      carry     = 1'b1;
      borrow    = min_borrow;
      for (int i = 0; i < MIN_DIGITS; i++) begin
         dig = mins_q[4*i +: 4];
         if (dig != 4'd9)
            all_nines = 1'b0;
         if (!carry)
            mins_inc[4*i +: 4] = dig;
         else if (dig == 4'd9)
            mins_inc[4*i +: 4] = 4'd0;
         else begin
            mins_inc[4*i +: 4] = dig + 4'd1;
            carry = 1'b0;
         end
         if (!borrow)
            mins_dec[4*i +: 4] = dig;
         else if (dig == 4'd0)
            mins_dec[4*i +: 4] = 4'd9;
         else begin
            mins_dec[4*i +: 4] = dig - 4'd1;
            borrow = 1'b0;
         end
      end
   end

   assign dec_is_zero = (ones_dec == 4'd0) && (tens_dec == 4'd0) && (mins_dec == '0);

   always_comb begin
      ones_d = ones_q;
      tens_d = tens_q;
      mins_d = mins_q;
      pre_d  = pre_q;
      done_d = 1'b0;
      if (load) begin
         pre_d = '0;
         if (data <= 4'd9) begin
            mins_d = (mins_q << 4) | tens_ext;
            tens_d = ones_q;
            ones_d = data;
         end
      end else if (add30) begin
         pre_d = '0;
         if (tens_q <= 4'd5) begin
            if (tens_q < 4'd3)
               tens_d = tens_q + 4'd3;
            else if (all_nines) begin
               tens_d = 4'd5;
               ones_d = 4'd9;
            end else begin
               tens_d = tens_q - 4'd3;
               mins_d = mins_inc;
            end
         end
      end else if (zero) begin
         pre_d = '0;
      end else if (en) begin
         if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            ones_d = ones_dec;
            tens_d = tens_dec;
            mins_d = mins_dec;
            done_d = dec_is_zero;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         ones_q <= 4'd0;
         tens_q <= 4'd0;
         mins_q <= '0;
         pre_q  <= '0;
         done_q <= 1'b0;
      end else begin
         ones_q <= ones_d;
         tens_q <= tens_d;
         mins_q <= mins_d;
         pre_q  <= pre_d;
         done_q <= done_d;
      end
   end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: two configurations driven in lockstep and
// checked against an integer-arithmetic reference model plus fixed vectors.
module tb_bcd_countdown_timer;

   logic       clk = 1'b0;
   logic       clr = 1'b0, load = 1'b0, add30 = 1'b0, en = 1'b0;
   logic [3:0] data = 4'd0;

   logic [3:0] ones_a, tens_a, ones_b, tens_b;
   logic [3:0] mins_a;
   logic [7:0] mins_b;
   logic       zero_a, done_a, zero_b, done_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bcd_countdown_timer #(.MIN_DIGITS(1), .TICK_DIV(1)) dut_a (
      .clk(clk), .clr(clr), .data(data), .load(load), .add30(add30), .en(en),
      .sec_ones(ones_a), .sec_tens(tens_a), .mins(mins_a), .zero(zero_a), .done(done_a));

   bcd_countdown_timer #(.MIN_DIGITS(2), .TICK_DIV(4)) dut_b (
      .clk(clk), .clr(clr), .data(data), .load(load), .add30(add30), .en(en),
      .sec_ones(ones_b), .sec_tens(tens_b), .mins(mins_b), .zero(zero_b), .done(done_b));

   // Model state: minutes as a plain integer, seconds as two decimal digits.
   typedef struct {
      int m;
      int t;
      int o;
      int pre;
      int done;
   } mstate_t;

   mstate_t ma, mb;

   function automatic int pow10(input int n);
      int r = 1;
      for (int k = 0; k < n; k++) r = r * 10;
      return r;
   endfunction

   function automatic int to_bcd(input int m);
      int r = 0;
      int v = m;
      for (int k = 0; k < 4; k++) begin
         r = r | ((v % 10) << (4 * k));
         v = v / 10;
      end
      return r;
   endfunction

   function automatic mstate_t step(input mstate_t s, input bit c, input bit l, input bit a,
                                    input bit e, input int d, input int nd, input int td);
      mstate_t n = s;
      int maxm = pow10(nd) - 1;
      bit is_zero = (s.m == 0) && (s.t == 0) && (s.o == 0);
      n.done = 0;
      if (c) begin
         n.m = 0; n.t = 0; n.o = 0; n.pre = 0;
      end else if (l) begin
         n.pre = 0;
         if (d <= 9) begin
            n.m = (s.m * 10 + s.t) % (maxm + 1);
            n.t = s.o;
            n.o = d;
         end
      end else if (a) begin
         n.pre = 0;
         if (s.t <= 5) begin
            if (s.t * 10 + s.o + 30 < 60) n.t = s.t + 3;
            else if (s.m == maxm) begin n.t = 5; n.o = 9; end
            else begin n.m = s.m + 1; n.t = s.t - 3; end
         end
      end else if (e && !is_zero) begin
         if (s.pre == td - 1) begin
            n.pre = 0;
            if (s.o > 0) n.o = s.o - 1;
            else if (s.t > 0) begin n.t = s.t - 1; n.o = 9; end
            else begin n.m = s.m - 1; n.t = 5; n.o = 9; end
            n.done = (n.m == 0 && n.t == 0 && n.o == 0) ? 1 : 0;
         end else begin
            n.pre = s.pre + 1;
         end
      end
      return n;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      ma = step(ma, clr, load, add30, en, int'(data), 1, 1);
      mb = step(mb, clr, load, add30, en, int'(data), 2, 4);
      #1;
      chk("a_ones", int'(ones_a), ma.o);
      chk("a_tens", int'(tens_a), ma.t);
      chk("a_mins", int'(mins_a), to_bcd(ma.m));
      chk("a_zero", int'(zero_a), (ma.m == 0 && ma.t == 0 && ma.o == 0) ? 1 : 0);
      chk("a_done", int'(done_a), ma.done);
      chk("b_ones", int'(ones_b), mb.o);
      chk("b_tens", int'(tens_b), mb.t);
      chk("b_mins", int'(mins_b), to_bcd(mb.m));
      chk("b_zero", int'(zero_b), (mb.m == 0 && mb.t == 0 && mb.o == 0) ? 1 : 0);
      chk("b_done", int'(done_b), mb.done);
   endtask

   task automatic drive(input bit c, input bit l, input bit a, input bit e, input logic [3:0] d);
      clr = c; load = l; add30 = a; en = e; data = d;
      cycle();
      clr = 1'b0; load = 1'b0; add30 = 1'b0;
   endtask

   task automatic chk_a(input string name, input int m, input int t, input int o);
      chk({name, "_mins"}, int'(mins_a), m);
      chk({name, "_tens"}, int'(tens_a), t);
      chk({name, "_ones"}, int'(ones_a), o);
   endtask

   typedef struct {
      bit         c, l, a, e;
      logic [3:0] d;
      int         o, t, m, z, dn;
   } vec_t;

   vec_t vt[15];
   int   done_cnt;

   initial begin
      ma = '{0, 0, 0, 0, 0};
      mb = '{0, 0, 0, 0, 0};
      // clr load add30 en data | ones tens mins zero done  (MIN_DIGITS=1, TICK_DIV=1)
      vt[0]  = '{1, 0, 0, 0, 4'h0, 0, 0, 0, 1, 0};
      vt[1]  = '{0, 1, 0, 0, 4'h4, 4, 0, 0, 0, 0};
      vt[2]  = '{0, 1, 0, 0, 4'h3, 3, 4, 0, 0, 0};
      vt[3]  = '{0, 1, 0, 0, 4'h2, 2, 3, 4, 0, 0};
      vt[4]  = '{0, 0, 0, 0, 4'h0, 2, 3, 4, 0, 0};
      vt[5]  = '{0, 1, 0, 1, 4'hA, 2, 3, 4, 0, 0};
      vt[6]  = '{0, 0, 1, 1, 4'h0, 2, 0, 5, 0, 0};
      vt[7]  = '{0, 0, 0, 1, 4'h0, 1, 0, 5, 0, 0};
      vt[8]  = '{0, 0, 0, 1, 4'h0, 0, 0, 5, 0, 0};
      vt[9]  = '{0, 0, 0, 1, 4'h0, 9, 5, 4, 0, 0};
      vt[10] = '{0, 1, 0, 1, 4'h9, 9, 9, 5, 0, 0};
      vt[11] = '{0, 0, 1, 1, 4'h0, 9, 9, 5, 0, 0};
      vt[12] = '{0, 0, 0, 1, 4'h0, 8, 9, 5, 0, 0};
      vt[13] = '{1, 1, 1, 1, 4'h3, 0, 0, 0, 1, 0};
      vt[14] = '{0, 0, 0, 1, 4'h0, 0, 0, 0, 1, 0};

      #2;
      for (int i = 0; i < 15; i++) begin
         drive(vt[i].c, vt[i].l, vt[i].a, vt[i].e, vt[i].d);
         chk($sformatf("vec%0d_ones", i), int'(ones_a), vt[i].o);
         chk($sformatf("vec%0d_tens", i), int'(tens_a), vt[i].t);
         chk($sformatf("vec%0d_mins", i), int'(mins_a), vt[i].m);
         chk($sformatf("vec%0d_zero", i), int'(zero_a), vt[i].z);
         chk($sformatf("vec%0d_done", i), int'(done_a), vt[i].dn);
      end

      // Paused hold: 4:32 stays put for 10 cycles with en=0.
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 4); drive(0, 1, 0, 0, 3); drive(0, 1, 0, 0, 2);
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0, 0, 0);
         chk_a("pause", 4, 3, 2);
      end

      // 1:00 down to 0:00 at one decrement per edge, single done pulse, no wrap.
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 1); drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 0);
      chk_a("load100", 1, 0, 0);
      drive(0, 0, 0, 1, 0);
      chk_a("first_dec", 0, 5, 9);
      done_cnt = 0;
      for (int i = 1; i < 60; i++) begin
         drive(0, 0, 0, 1, 0);
         if (done_a) done_cnt++;
      end
      chk_a("end60", 0, 0, 0);
      chk("end60_done", int'(done_a), 1);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 0);
         if (done_a) done_cnt++;
      end
      chk_a("nowrap", 0, 0, 0);
      chk("nowrap_zero", int'(zero_a), 1);
      chk("done_pulses", done_cnt, 1);

      // TICK_DIV=4: fraction preserved across a pause.
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 5);
      for (int i = 1; i <= 6; i++) begin
         drive(0, 0, 0, 1, 0);
         chk($sformatf("div4_e%0d", i), int'(ones_b), (i < 4) ? 5 : 4);
      end
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
      chk("div4_paused", int'(ones_b), 4);
      drive(0, 0, 0, 1, 0);
      chk("div4_resume1", int'(ones_b), 4);
      drive(0, 0, 0, 1, 0);
      chk("div4_resume2", int'(ones_b), 3);

      // +30 s cases.
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 4); drive(0, 1, 0, 0, 5); drive(0, 0, 1, 0, 0);
      chk_a("add_045", 1, 1, 5);
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 2); drive(0, 1, 0, 0, 0); drive(0, 0, 1, 0, 0);
      chk_a("add_020", 0, 5, 0);
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 9); drive(0, 1, 0, 0, 4); drive(0, 1, 0, 0, 5); drive(0, 0, 1, 0, 0);
      chk_a("add_sat", 9, 5, 9);
      chk("add_945_b", int'(mins_b), 8'h10);
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 9); drive(0, 1, 0, 0, 9); drive(0, 0, 1, 0, 0);
      chk_a("add_099", 0, 9, 9);
      drive(0, 0, 0, 1, 0);
      chk_a("dec_099", 0, 9, 8);

      // Two minute digits: first digit shifted out, then borrow chain at 20:00.
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 1); drive(0, 1, 0, 0, 2); drive(0, 1, 0, 0, 0);
      drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 5);
      chk("m2_load_mins", int'(mins_b), 8'h20);
      chk("m2_load_secs", int'({tens_b, ones_b}), 8'h05);
      for (int i = 0; i < 24; i++) drive(0, 0, 0, 1, 0);
      chk("m2_borrow_mins", int'(mins_b), 8'h19);
      chk("m2_borrow_secs", int'({tens_b, ones_b}), 8'h59);

      // Invalid digit ignored; clr mid-countdown gives no done.
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 2); drive(0, 1, 0, 0, 4'hC);
      chk_a("bad_digit", 0, 0, 2);
      drive(0, 0, 0, 1, 0);
      chk_a("pre_clr", 0, 0, 1);
      drive(1, 0, 0, 1, 0);
      chk_a("clr_mid", 0, 0, 0);
      chk("clr_mid_done", int'(done_a), 0);
      drive(0, 0, 0, 1, 0);
      chk("clr_after_done", int'(done_a), 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 500; i++) begin
         drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20),
               ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 75),
               4'($urandom_range(0, 15)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
